// File: rtl/ls_pkg.sv
// Shared definitions for the load/store unit: function codes, access
// lengths, FSM state encoding and the op legality/alignment check.
package ls_pkg;

    // Load function codes
    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    // Store function codes
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    // Memory access length codes
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ls_state_e;

    // 1 when the op is an unknown encoding or its address is not
    // naturally aligned for its access size.
    function automatic logic op_fault(input logic       is_store,
                                      input logic [2:0] funct,
                                      input logic [1:0] addr_lo);
        logic illegal;
        logic misal;
        if (is_store)
            illegal = !(funct inside {F_SB, F_SH, F_SW});
        else
            illegal = !(funct inside {F_LB, F_LH, F_LW, F_LBU, F_LHU});
        misal = ((funct[1:0] == 2'b01) && addr_lo[0]) ||
                ((funct[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal | misal;
    endfunction

    // Access length for a legal op; funct[1:0] selects the size.
    function automatic logic [1:0] op_len(input logic [2:0] funct);
        case (funct[1:0])
            2'b00:   return LEN_B;
            2'b01:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/ls_queue.sv
// Synchronous FIFO holding issued load/store ops. rdy freezes all state;
// a flush (while enabled) empties it and drops a coincident push.
module ls_queue
    import ls_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = rdy & push & ~full  & ~flush;
    assign do_pop  = rdy & pop  & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (rdy && flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ls_unit.sv
// Load/store execution unit: queues issued ops, runs them one at a time
// against the memory controller and broadcasts a one-cycle result.
module ls_unit
    import ls_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_FREE = 0,
    parameter int QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct,
    input  logic [DATA_W-1:0] in_base,
    input  logic [DATA_W-1:0] in_offset,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              res_valid,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_data,
    output logic              res_exc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_len,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int QW = 1 + 3 + ADDR_W + DATA_W + TAG_W;
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_FREE);

    // Sign/zero extension of the low-aligned read data; funct[2] selects zero.
    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0]  funct,
                                                   input logic [31:0] raw);
        case (funct)
            F_LB:    return DATA_W'($signed(raw[7:0]));
            F_LBU:   return DATA_W'(raw[7:0]);
            F_LH:    return DATA_W'($signed(raw[15:0]));
            F_LHU:   return DATA_W'(raw[15:0]);
            default: return DATA_W'($signed(raw));
        endcase
    endfunction

    ls_state_e         state_q;
    logic              cur_store_q;
    logic [2:0]        cur_funct_q;
    logic [TAG_W-1:0]  cur_tag_q;
    logic              killed_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        mem_len_q;
    logic              res_valid_q;
    logic [TAG_W-1:0]  res_tag_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_exc_q;

    logic [ADDR_W-1:0] push_addr;
    logic [QW-1:0]     q_wdata;
    logic [QW-1:0]     q_rdata;
    logic              q_full;
    logic              q_empty;
    logic              q_pop;
    logic [$clog2(QDEPTH):0] q_count;

    logic              ent_store;
    logic [2:0]        ent_funct;
    logic [ADDR_W-1:0] ent_addr;
    logic [DATA_W-1:0] ent_sdata;
    logic [TAG_W-1:0]  ent_tag;

    assign push_addr = ADDR_W'(in_base + in_offset);
    assign q_wdata   = {in_is_store, in_funct, push_addr, in_sdata, in_tag};
    assign {ent_store, ent_funct, ent_addr, ent_sdata, ent_tag} = q_rdata;
    assign q_pop     = (state_q == ST_IDLE) & ~flush;

    ls_queue #(
        .WIDTH (QW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .flush (flush),
        .push  (in_valid),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign in_ready  = ~q_full;
    assign busy      = (q_count != '0) || (state_q != ST_IDLE);
    // A flush in the response cycle still cancels the broadcast
    assign res_valid = res_valid_q & ~(rdy & flush);
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
    assign res_exc   = res_exc_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_len   = mem_len_q;

    // Op sequencer: pop, access memory (or fault), respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_store_q <= 1'b0;
            cur_funct_q <= '0;
            cur_tag_q   <= TAG_NONE;
            killed_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_len_q   <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= TAG_NONE;
            res_data_q  <= '0;
            res_exc_q   <= 1'b0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (!q_empty && !flush) begin
                        cur_store_q <= ent_store;
                        cur_funct_q <= ent_funct;
                        cur_tag_q   <= ent_tag;
                        killed_q    <= 1'b0;
                        if (op_fault(ent_store, ent_funct, ent_addr[1:0])) begin
                            res_valid_q <= (ent_tag != TAG_NONE);
                            res_tag_q   <= ent_tag;
                            res_data_q  <= '0;
                            res_exc_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ent_store;
                            mem_addr_q  <= ent_addr;
                            mem_wdata_q <= ent_store ? ent_sdata : '0;
                            mem_len_q   <= op_len(ent_funct);
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) killed_q <= 1'b1;
                    if (mem_done) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_len_q   <= '0;
                        res_valid_q <= !(killed_q || flush) && (cur_tag_q != TAG_NONE);
                        res_tag_q   <= cur_tag_q;
                        res_data_q  <= cur_store_q ? '0 : load_ext(cur_funct_q, mem_rdata[31:0]);
                        res_exc_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    res_valid_q <= 1'b0;
                    res_exc_q   <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: loads, stores, exceptions, queue full,
// flush, rdy stall and asynchronous reset.
module tb_ls_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_store;
    logic [2:0]        in_funct;
    logic [DATA_W-1:0] in_base;
    logic [DATA_W-1:0] in_offset;
    logic [DATA_W-1:0] in_sdata;
    logic [TAG_W-1:0]  in_tag;
    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic [DATA_W-1:0] res_data;
    logic              res_exc;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_len;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    ls_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .TAG_FREE(0), .QDEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct(in_funct), .in_base(in_base), .in_offset(in_offset),
        .in_sdata(in_sdata), .in_tag(in_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_exc(res_exc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic st, input logic [2:0] f, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] sd, input logic [3:0] tg);
        in_is_store = st;
        in_funct    = f;
        in_base     = base;
        in_offset   = off;
        in_sdata    = sd;
        in_tag      = tg;
    endtask

    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd, input logic [3:0] tg);
        set_op(st, f, base, off, sd, tg);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, answer after dly cycles.
    task automatic do_access(input string nm, input logic [31:0] exp_addr, input logic [31:0] rd,
                             input int dly, input logic [3:0] exp_tag, input logic [31:0] exp_data);
        for (int i = 0; i < 20; i++) begin
            if (mem_req) break;
            tick();
        end
        chk({nm, "_req"}, mem_req, 1);
        chk({nm, "_addr"}, mem_addr, exp_addr);
        for (int i = 0; i < dly; i++) tick();
        chk({nm, "_req_held"}, mem_req, 1);
        mem_rdata = rd;
        mem_done  = 1'b1;
        tick();
        mem_done  = 1'b0;
        chk({nm, "_vld"}, res_valid, 1);
        chk({nm, "_tag"}, res_tag, exp_tag);
        chk({nm, "_data"}, res_data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        mem_done = 1'b0; mem_rdata = '0;
        set_op(1'b0, 3'b000, 0, 0, 0, 0);
        #3;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        #10 rst_n = 1'b1;
        tick();

        // LB 0x103 -> sign extended
        issue(1'b0, 3'b000, 32'h100, 32'h3, 0, 4'd1);
        tick();
        chk("lb_req", mem_req, 1);
        chk("lb_addr", mem_addr, 32'h103);
        chk("lb_len", mem_len, 2'b00);
        chk("lb_we", mem_we, 0);
        mem_rdata = 32'h0000_00F0; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("lb_vld", res_valid, 1);
        chk("lb_tag", res_tag, 1);
        chk("lb_data", res_data, 32'hFFFF_FFF0);
        chk("lb_exc", res_exc, 0);
        chk("lb_req_drop", mem_req, 0);
        tick();
        chk("lb_vld_one", res_valid, 0);
        chk("lb_idle", busy, 0);

        // LBU same address -> zero extended
        issue(1'b0, 3'b100, 32'h100, 32'h3, 0, 4'd2);
        do_access("lbu", 32'h103, 32'h0000_00F0, 0, 4'd2, 32'h0000_00F0);
        tick();

        // SW tag 5
        issue(1'b1, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 4'd5);
        tick();
        chk("sw_we", mem_we, 1);
        chk("sw_len", mem_len, 2'b11);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); tick(); tick();
        chk("sw_we_held", mem_we, 1);
        chk("sw_wdata_held", mem_wdata, 32'hDEAD_BEEF);
        do_access("sw", 32'h200, 32'h1234_5678, 0, 4'd5, 32'h0);
        tick();

        // SW with free tag -> no result pulse
        issue(1'b1, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 4'd0);
        tick();
        chk("swf_req", mem_req, 1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("swf_novld", res_valid, 0);
        tick();
        chk("swf_idle", busy, 0);

        // LH misaligned -> exception, no memory access
        issue(1'b0, 3'b001, 32'h100, 32'h1, 0, 4'd3);
        tick();
        chk("lhm_req", mem_req, 0);
        chk("lhm_vld", res_valid, 1);
        chk("lhm_exc", res_exc, 1);
        chk("lhm_tag", res_tag, 3);
        chk("lhm_data", res_data, 0);
        tick();
        chk("lhm_vld_one", res_valid, 0);
        chk("lhm_exc_one", res_exc, 0);
        chk("lhm_req2", mem_req, 0);

        // Illegal load funct 011
        issue(1'b0, 3'b011, 32'h100, 32'h0, 0, 4'd4);
        tick();
        chk("ill_req", mem_req, 0);
        chk("ill_vld", res_valid, 1);
        chk("ill_exc", res_exc, 1);
        chk("ill_tag", res_tag, 4);
        tick();
        tick();

        // Fill the queue: A is popped, B..E fill four entries
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(1'b0, 3'b010, 32'h400 + 32'(4 * i), 0, 0, 4'(i + 1));
            tick();
        end
        chk("full_ready", in_ready, 0);
        set_op(1'b0, 3'b010, 32'h500, 0, 0, 4'd6);
        tick();
        in_valid = 1'b0;
        chk("full_ready2", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            do_access("fifo", 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 10,
                      4'(i + 1), 32'h1000 + 32'(i));
        end
        tick(); tick(); tick();
        chk("fifo_drop_req", mem_req, 0);
        chk("fifo_drop_busy", busy, 0);

        // Flush with A in WAIT and B, C queued
        in_valid = 1'b1;
        set_op(1'b0, 3'b010, 32'h600, 0, 0, 4'd6); tick();
        set_op(1'b0, 3'b010, 32'h604, 0, 0, 4'd7); tick();
        set_op(1'b0, 3'b010, 32'h608, 0, 0, 4'd8); tick();
        in_valid = 1'b0;
        chk("fl_req", mem_req, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_ready", in_ready, 1);
        chk("fl_req_held", mem_req, 1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("fl_novld", res_valid, 0);
        chk("fl_req_drop", mem_req, 0);
        tick();
        chk("fl_novld2", res_valid, 0);
        chk("fl_busy", busy, 0);
        tick(); tick();
        chk("fl_no_more_req", mem_req, 0);

        // rdy stall during WAIT with mem_done toggling
        issue(1'b0, 3'b010, 32'h300, 0, 0, 4'd9);
        tick();
        chk("rdy_req", mem_req, 1);
        rdy = 1'b0;
        mem_rdata = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            mem_done = ~mem_done;
            tick();
        end
        chk("rdy_req_hold", mem_req, 1);
        chk("rdy_novld", res_valid, 0);
        chk("rdy_addr_hold", mem_addr, 32'h300);
        rdy = 1'b1;
        mem_done = 1'b0;
        tick();
        chk("rdy_still_wait", mem_req, 1);
        do_access("rdy", 32'h300, 32'h0000_0077, 0, 4'd9, 32'h0000_0077);
        tick();

        // Asynchronous reset in the middle of an access
        issue(1'b0, 3'b010, 32'h700, 0, 0, 4'd10);
        tick();
        chk("ar_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req0", mem_req, 0);
        chk("ar_addr0", mem_addr, 0);
        chk("ar_busy0", busy, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_tag", res_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_after", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
